dpram_port_arbiter: RTL and testbench
=====================================

# dpram_port_arbiter

Round-robin arbiter that shares port B of the 64K×16 true dual-port block RAM between several on-chip requesters, such as the fret-timing table reader, the display fetch and the I/O engine; port A stays with the CPU. The block serialises single-word read and write requests onto the RAM port at up to one access per cycle. It steers the registered RAM output back to the winning requester with a per-requester valid pulse. An optional write-protect window guards the fret table at 16'hF000 and up from all requesters except requester 0.

## Interface
- NUM_REQ, 3, number of requesters (2–8)
- ADDR_W, 16, RAM address width
- DATA_W, 16, RAM word width
- PROT_BASE, 16'hF000, lowest protected address (used only with the write-protect macro)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester access request, level, held until gnt
- we  in  NUM_REQ  per-requester write (1) / read (0) qualifier
- addr  in  NUM_REQ*ADDR_W  flattened request addresses, requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_REQ*DATA_W  flattened write data, same packing
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- rvalid  out  NUM_REQ  one-hot, one-cycle completion pulse
- rdata  out  DATA_W  completion data, equal to ram_q
- err  out  1  one-cycle protection-violation pulse
- ram_en  out  1  RAM port B write enable
- ram_addr  out  ADDR_W  RAM port B address
- ram_data  out  DATA_W  RAM port B write data
- ram_q  in  DATA_W  RAM port B registered output

## Operation
- Requester protocol:
  - The requester asserts req[i] and holds we/addr/wdata stable until it sees gnt[i].
  - The arbiter captures the request on the edge that raises gnt[i], so inputs may change in the gnt cycle.
  - A requester that drops req before it is granted is ignored, and no access occurs.
- Arbitration is round-robin:
  - Search starts at last_winner+1 and wraps modulo NUM_REQ.
  - last_winner updates only on a grant.
  - Reset value of last_winner is NUM_REQ-1, so requester 0 has first priority.
- Issue stage (registered):
  - ram_addr and ram_data take the winner's addr/wdata.
  - ram_en takes the winner's we.
  - With no winner, ram_en = 0 and ram_addr/ram_data hold their values.
- Response stage:
  - A registered pipe of valid bit plus winner id, one stage deep, drives rvalid[id] in the cycle the RAM output reflects the access.
  - Reads return the stored word.
  - Writes return the written word, because the RAM port is write-first; a write's rvalid is its completion acknowledgement.
- Pipelining: a new grant may be issued every cycle, and accesses complete strictly in grant order.
- Reset:
  - Reset values: gnt=0, rvalid=0, err=0, ram_en=0, ram_addr=0, ram_data=0, last_winner=NUM_REQ-1, pipe valid=0.
  - Reset asserted mid-operation drops any in-flight rvalid.
  - A write already presented to the RAM on the preceding edge is not undone.

## Timing
- Latency when idle: req[i] high in cycle N, then gnt[i] high in N+1, then rvalid[i] high with rdata valid in N+2.
- Sustained throughput is 1 access per cycle across all requesters.
- Under full load, requester i waits at most NUM_REQ-1 cycles after its turn opens.
- rdata is a combinational passthrough of ram_q and is qualified only by rvalid.
- All other outputs are registered.

## Configuration
- Macro DPRAM_ARB_WRITE_PROTECT_EN.
- When defined:
  - A granted write from requester i≠0 with addr ≥ PROT_BASE is issued as a read (ram_en=0).
  - err pulses in the gnt cycle.
  - rvalid still pulses, carrying the unchanged stored word.
- When undefined:
  - All writes pass through unchanged.
  - err is tied to 0.

## Structure
- Package dpram_arb_pkg holds the ADDR_W/DATA_W defaults, PROT_BASE, and a localparam for the requester-id width, $clog2(NUM_REQ).
- Sub-module rr_picker: combinational round-robin select taking req and last_winner, producing a one-hot winner plus its id.
- The top level holds the issue registers, the response pipe and the protection check.

## Test plan
- Single read: RAM[16'h0010]=16'h1234; req[1]=1, we=0, addr=16'h0010 -> gnt[1] next cycle, then rvalid[1] with rdata=16'h1234 one cycle later.
- Write then read: requester 2 writes 16'hBEEF to 16'h0200, then reads 16'h0200 -> the write's rvalid shows 16'hBEEF, and the read returns 16'hBEEF.
- Contention: all 3 req held for 6 cycles after reset -> grant order 0,1,2,0,1,2, one grant per cycle, and rvalid order matches.
- Drop before grant: req[2] pulsed for the single cycle in which requester 0 wins -> no gnt[2], ram_en stays 0 for requester 2, no rvalid[2].
- Reset mid-flight: reset asserted in the gnt cycle of a read -> gnt, rvalid and ram_en are 0 immediately; the first grant after release goes to requester 0.
- With DPRAM_ARB_WRITE_PROTECT_EN: requester 1 writes 16'h0001 to 16'hF003, which holds 12'd500 -> err pulse, ram_en=0, rvalid[1] with rdata=16'h01F4. The same write from requester 0 succeeds.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// rtl/dpram_arb_pkg.sv - shared defaults and helpers for the DPRAM port-B arbiter
package dpram_arb_pkg;

  localparam int          NUM_REQ_DEF   = 3;
  localparam int          ADDR_W_DEF    = 16;
  localparam int          DATA_W_DEF    = 16;
  localparam logic [15:0] PROT_BASE_DEF = 16'hF000;
  localparam int          REQ_ID_W      = $clog2(NUM_REQ_DEF);

  // Requester-id width for an arbitrary requester count, never narrower than one bit.
  function automatic int req_id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin select, search starts at last_winner+1
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_winner,
  output logic [NUM_REQ-1:0] winner,
  output logic [ID_W-1:0]    winner_id,
  output logic               any_req
);

  logic [NUM_REQ-1:0] above;
  logic [NUM_REQ-1:0] cand;

  // Requesters above last_winner take precedence; otherwise wrap to the lowest index.
  always_comb begin
    above = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      above[i] = (ID_W'(i) > last_winner);
    end
    cand = ((req & above) != '0) ? (req & above) : req;
    winner    = '0;
    winner_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
        winner_id = ID_W'(i);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - round-robin sharing of DPRAM port B among on-chip requesters
// Optional fret-table write protection: define DPRAM_ARB_WRITE_PROTECT_EN.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int                NUM_REQ   = NUM_REQ_DEF,
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(PROT_BASE_DEF)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic                      ram_en,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_data,
  input  logic [DATA_W-1:0]         ram_q
);

  localparam int ID_W = req_id_width(NUM_REQ);

`ifdef DPRAM_ARB_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_a [NUM_REQ];

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_a[g]  = addr[g*ADDR_W +: ADDR_W];
      assign wdata_a[g] = wdata[g*DATA_W +: DATA_W];
    end
  endgenerate

  logic [ID_W-1:0]    last_winner;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  logic               win_we;
  logic               prot_viol;
  logic               pipe_valid;
  logic [ID_W-1:0]    pipe_id;

  // A requester still holding req during its gnt cycle must not be granted twice.
  assign eligible = req & ~gnt;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_picker (
    .req         (eligible),
    .last_winner (last_winner),
    .winner      (pick_onehot),
    .winner_id   (pick_id),
    .any_req     (pick_any)
  );

  assign win_we    = pick_any & we[pick_id];
  assign prot_viol = WP_EN && win_we && (pick_id != '0) && (addr_a[pick_id] >= PROT_BASE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt         <= '0;
      err         <= 1'b0;
      ram_en      <= 1'b0;
      ram_addr    <= '0;
      ram_data    <= '0;
      last_winner <= ID_W'(NUM_REQ - 1);
      pipe_valid  <= 1'b0;
      pipe_id     <= '0;
    end else begin
      gnt        <= pick_onehot;
      err        <= prot_viol;
      ram_en     <= win_we & ~prot_viol;
      pipe_valid <= pick_any;
      pipe_id    <= pick_id;
      if (pick_any) begin
        ram_addr    <= addr_a[pick_id];
        ram_data    <= wdata_a[pick_id];
        last_winner <= pick_id;
      end
    end
  end

  // Completion lands one cycle after issue, when the registered RAM output reflects it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid <= '0;
    end else begin
      rvalid <= '0;
      if (pipe_valid) begin
        rvalid[pipe_id] <= 1'b1;
      end
    end
  end

  assign rdata = ram_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb/tb_dpram_port_arbiter.sv - directed self-checking bench for dpram_port_arbiter
module tb_dpram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [47:0] addr;
  logic [47:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [15:0] rdata;
  logic        err;
  logic        ram_en;
  logic [15:0] ram_addr;
  logic [15:0] ram_data;
  logic [15:0] ram_q = 16'h0000;

  logic        bd_we;
  logic [15:0] bd_addr;
  logic [15:0] bd_data;
  logic [15:0] mem [0:65535];
  logic [15:0] cont_q [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dpram_port_arbiter u_dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .err      (err),
    .ram_en   (ram_en),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_q    (ram_q)
  );

  // Port B of the block RAM: registered, write-first, plus a bench-only preload path.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_en) mem[ram_addr] <= ram_data;
    ram_q <= ram_en ? ram_data : mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  // One isolated access from an idle arbiter: gnt cycle, then completion cycle.
  task automatic access(input int id, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic exp_en, input logic exp_err, input logic [15:0] exp_q,
                        input string tag);
    req              = '0;
    req[id]          = 1'b1;
    we[id]           = w;
    addr[id*16 +: 16]  = a;
    wdata[id*16 +: 16] = d;
    @(negedge clk);
    chk({tag, ".gnt"}, 32'(gnt), 32'(1 << id));
    chk({tag, ".ram_en"}, 32'(ram_en), 32'(exp_en));
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(a));
    if (w) chk({tag, ".ram_data"}, 32'(ram_data), 32'(d));
    req = '0;
    @(negedge clk);
    chk({tag, ".rvalid"}, 32'(rvalid), 32'(1 << id));
    chk({tag, ".rdata"}, 32'(rdata), 32'(exp_q));
    chk({tag, ".gnt_idle"}, 32'(gnt), 32'h0);
    chk({tag, ".err_idle"}, 32'(err), 32'h0);
  endtask

  initial begin
    reset  = 1'b1;
    req    = '0;
    we     = '0;
    addr   = '0;
    wdata  = '0;
    bd_we  = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    cont_q[0] = 16'hAAAA;
    cont_q[1] = 16'hBBBB;
    cont_q[2] = 16'hCCCC;
    repeat (2) @(negedge clk);
    preload(16'h0010, 16'h1234);
    preload(16'hF003, 16'h01F4);
    preload(16'hF000, 16'h7777);
    preload(16'h0100, 16'hAAAA);
    preload(16'h0101, 16'hBBBB);
    preload(16'h0102, 16'hCCCC);

    chk("rst.gnt", 32'(gnt), 32'h0);
    chk("rst.rvalid", 32'(rvalid), 32'h0);
    chk("rst.err", 32'(err), 32'h0);
    chk("rst.ram_en", 32'(ram_en), 32'h0);
    chk("rst.ram_addr", 32'(ram_addr), 32'h0);
    chk("rst.ram_data", 32'(ram_data), 32'h0);

    // Contention: all three requesters held for six cycles straight out of reset.
    reset = 1'b0;
    we    = 3'b000;
    addr  = {16'h0102, 16'h0101, 16'h0100};
    req   = 3'b111;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("cont.gnt%0d", k), 32'(gnt), 32'(1 << ((k - 1) % 3)));
      if (k >= 2) begin
        chk($sformatf("cont.rvalid%0d", k), 32'(rvalid), 32'(1 << ((k - 2) % 3)));
        chk($sformatf("cont.rdata%0d", k), 32'(rdata), 32'(cont_q[(k - 2) % 3]));
      end
      if (k == 6) req = '0;
    end
    @(negedge clk);
    chk("cont.gnt_end", 32'(gnt), 32'h0);
    chk("cont.rvalid_last", 32'(rvalid), 32'h4);
    chk("cont.rdata_last", 32'(rdata), 32'hCCCC);
    @(negedge clk);
    chk("cont.rvalid_idle", 32'(rvalid), 32'h0);

    // Requester 2 pulses req only in the cycle requester 0 wins.
    we    = 3'b100;
    addr  = {16'h0300, 16'h0000, 16'h0100};
    wdata = {16'h5A5A, 16'h0000, 16'h0000};
    req   = 3'b101;
    @(negedge clk);
    chk("drop.gnt", 32'(gnt), 32'h1);
    chk("drop.ram_en0", 32'(ram_en), 32'h0);
    req = '0;
    @(negedge clk);
    chk("drop.gnt_none", 32'(gnt), 32'h0);
    chk("drop.ram_en1", 32'(ram_en), 32'h0);
    chk("drop.rvalid0", 32'(rvalid), 32'h1);
    @(negedge clk);
    chk("drop.rvalid_none", 32'(rvalid), 32'h0);
    chk("drop.ram_en2", 32'(ram_en), 32'h0);

    access(1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h1234, "rd1");
    access(2, 1'b1, 16'h0200, 16'hBEEF, 1'b1, 1'b0, 16'hBEEF, "wr2");
    access(2, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0, 16'hBEEF, "rd2");

`ifdef DPRAM_ARB_WRITE_PROTECT_EN
    access(1, 1'b1, 16'hF003, 16'h0001, 1'b0, 1'b1, 16'h01F4, "wp.r1");
    access(1, 1'b0, 16'hF003, 16'h0000, 1'b0, 1'b0, 16'h01F4, "wp.r1chk");
    access(0, 1'b1, 16'hF003, 16'h0001, 1'b1, 1'b0, 16'h0001, "wp.r0");
    access(2, 1'b1, 16'hF000, 16'h5555, 1'b0, 1'b1, 16'h7777, "wp.base");
    access(1, 1'b1, 16'hEFFF, 16'h1111, 1'b1, 1'b0, 16'h1111, "wp.below");
`else
    access(1, 1'b1, 16'hF003, 16'h0001, 1'b1, 1'b0, 16'h0001, "wp.r1");
    access(1, 1'b0, 16'hF003, 16'h0000, 1'b0, 1'b0, 16'h0001, "wp.r1chk");
    access(0, 1'b1, 16'hF003, 16'h0002, 1'b1, 1'b0, 16'h0002, "wp.r0");
    access(2, 1'b1, 16'hF000, 16'h5555, 1'b1, 1'b0, 16'h5555, "wp.base");
    access(1, 1'b1, 16'hEFFF, 16'h1111, 1'b1, 1'b0, 16'h1111, "wp.below");
`endif

    // Reset lands in the gnt cycle of a read from requester 1.
    we   = 3'b000;
    addr = {16'h0102, 16'h0010, 16'h0100};
    req  = 3'b010;
    @(negedge clk);
    chk("mid.gnt", 32'(gnt), 32'h2);
    reset = 1'b1;
    #1;
    chk("mid.gnt_rst", 32'(gnt), 32'h0);
    chk("mid.rvalid_rst", 32'(rvalid), 32'h0);
    chk("mid.ram_en_rst", 32'(ram_en), 32'h0);
    chk("mid.ram_addr_rst", 32'(ram_addr), 32'h0);
    req = '0;
    @(negedge clk);
    chk("mid.rvalid_held", 32'(rvalid), 32'h0);
    reset = 1'b0;
    req   = 3'b111;
    @(negedge clk);
    chk("mid.first_gnt", 32'(gnt), 32'h1);
    req = '0;
    @(negedge clk);
    chk("mid.rvalid", 32'(rvalid), 32'h1);
    chk("mid.rdata", 32'(rdata), 32'hAAAA);
    @(negedge clk);
    chk("mid.idle", 32'(rvalid | gnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
